// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared iterative divider.
// Accepts one operation at a time, launches it, waits for completion or timeout, returns a response.
module div_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_ctrl,
    input  logic [31:0] req0_num,
    input  logic [31:0] req0_den,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_ctrl,
    input  logic [31:0] req1_num,
    input  logic [31:0] req1_den,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        div_start,
    output logic [1:0]  div_ctrl,
    output logic [31:0] div_numerator,
    output logic [31:0] div_denominator,
    input  logic [31:0] div_result,
    input  logic        div_done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                id_q, id_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   num_q, num_d;
    logic [DATA_W-1:0]   den_q, den_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                div_start_q, div_start_d;

    logic                grant_c;
    logic                accept_c;

    // Round-robin: on a tie the requester not served last wins.
    assign grant_c    = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    // Ready is combinational from valid; held low while reset is asserted.
    assign req0_ready = rst_n && (state_q == ST_IDLE) && req0_valid && !grant_c;
    assign req1_ready = rst_n && (state_q == ST_IDLE) && req1_valid && grant_c;
    assign accept_c   = req0_ready || req1_ready;

    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = id_q;
    assign rsp_result      = result_q;
    assign rsp_err         = err_q;
    assign div_start       = div_start_q;
    assign div_ctrl        = ctrl_q;
    assign div_numerator   = num_q;
    assign div_denominator = den_q;

    // State and captured-operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            ctrl_q      <= '0;
            num_q       <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            ctrl_q      <= ctrl_d;
            num_q       <= num_d;
            den_q       <= den_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            div_start_q <= div_start_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        ctrl_d      = ctrl_q;
        num_d       = num_q;
        den_d       = den_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        div_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    id_d        = grant_c;
                    ctrl_d      = grant_c ? req1_ctrl : req0_ctrl;
                    num_d       = grant_c ? req1_num  : req0_num;
                    den_d       = grant_c ? req1_den  : req0_den;
                    div_start_d = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                // div_done may still be high from the previous operation; ignore it here.
                cnt_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (div_done) begin
                    result_d    = div_result;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d    = '1;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_d      = id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
